// File: rtl/sc_mac_sequencer_pkg.sv
// Shared definitions for the stochastic-computing MAC blocks: FSM encoding,
// default precision and the width/window helpers derived from it.
package sc_mac_sequencer_pkg;

    localparam int SC_W_DEFAULT = 7;

    typedef enum logic [2:0] {
        SC_IDLE  = 3'd0,
        SC_CLEAR = 3'd1,
        SC_PRIME = 3'd2,
        SC_RUN   = 3'd3,
        SC_DONE  = 3'd4
    } sc_state_e;

    // Ones-count width: one window holds up to 2^W ones, N terms add clog2(N) bits.
    function automatic int sc_acc_width(input int w, input int n_terms);
        return w + 1 + $clog2(n_terms);
    endfunction

    function automatic int sc_win_len(input int w);
        return 1 << w;
    endfunction

    localparam int SC_WIN_LEN_DEFAULT = sc_win_len(SC_W_DEFAULT);

endpackage

// File: rtl/sc_window_counter.sv
// Window framing counter: W+1 bits, synchronous clear and enable, and a flag
// on the enabled cycle that closes a 2^W-cycle window.
module sc_window_counter
    import sc_mac_sequencer_pkg::*;
#(
    parameter int W = SC_W_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [W:0] WIN_LAST = (W+1)'(sc_win_len(W) - 1);

    logic [W:0] cnt_q;
    logic [W:0] cnt_d;

    // Next count: clear dominates enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {(W+1){1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + (W+1)'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {(W+1){1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = en_i && (cnt_q == WIN_LAST);

endmodule

// File: rtl/sc_mac_sequencer.sv
// Sequencer for the deterministic SC MAC: accepts operand pairs, clears and
// primes the stream generators, and counts product ones over N_TERMS windows.
module sc_mac_sequencer
    import sc_mac_sequencer_pkg::*;
#(
    parameter int W       = SC_W_DEFAULT,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = sc_acc_width(W, N_TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [W-1:0]     sng_x,
    output logic [W-1:0]     sng_y,
    output logic             sng_rst,
    input  logic             prod_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc
);

    localparam logic [2:0] ST_IDLE  = SC_IDLE;
    localparam logic [2:0] ST_CLEAR = SC_CLEAR;
    localparam logic [2:0] ST_PRIME = SC_PRIME;
    localparam logic [2:0] ST_RUN   = SC_RUN;
    localparam logic [2:0] ST_DONE  = SC_DONE;

    localparam int TERM_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [TERM_W-1:0] TERM_LAST = TERM_W'(N_TERMS - 1);

    logic [2:0]        state_q, state_d;
    logic [W-1:0]      sng_x_q, sng_x_d;
    logic [W-1:0]      sng_y_q, sng_y_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic [TERM_W-1:0] term_q, term_d;
    logic              in_ready_q;
    logic              sng_rst_q;
    logic              out_valid_q;

    logic              accept_s;
    logic              win_clr_s;
    logic              win_en_s;
    logic              win_last_s;

    assign accept_s = in_valid && in_ready_q && (state_q == ST_IDLE);

    sc_window_counter #(
        .W (W)
    ) u_win (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (win_clr_s),
        .en_i   (win_en_s),
        .last_o (win_last_s)
    );

    // Sequencing FSM, operand capture and ones accumulation.
    always_comb begin
        state_d   = state_q;
        sng_x_d   = sng_x_q;
        sng_y_d   = sng_y_q;
        acc_d     = acc_q;
        out_acc_d = out_acc_q;
        term_d    = term_q;
        win_clr_s = 1'b0;
        win_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    sng_x_d = in_a;
                    sng_y_d = in_b;
                    if (term_q == {TERM_W{1'b0}}) begin
                        acc_d = {ACC_W{1'b0}};
                    end else begin
                        acc_d = acc_q;
                    end
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_PRIME;
            end
            ST_PRIME: begin
                // The SNGs emit their counter-0 bit at the end of this cycle.
                win_clr_s = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                win_en_s = 1'b1;
                acc_d    = acc_q + ACC_W'(prod_bit);
                if (win_last_s) begin
                    if (term_q == TERM_LAST) begin
                        out_acc_d = acc_d;
                        state_d   = ST_DONE;
                    end else begin
                        term_d  = term_q + TERM_W'(1);
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    term_d  = {TERM_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sng_x_q     <= {W{1'b0}};
            sng_y_q     <= {W{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            out_acc_q   <= {ACC_W{1'b0}};
            term_q      <= {TERM_W{1'b0}};
            in_ready_q  <= 1'b0;
            sng_rst_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sng_x_q     <= sng_x_d;
            sng_y_q     <= sng_y_d;
            acc_q       <= acc_d;
            out_acc_q   <= out_acc_d;
            term_q      <= term_d;
            in_ready_q  <= (state_d == ST_IDLE);
            sng_rst_q   <= (state_d != ST_CLEAR);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign sng_x     = sng_x_q;
    assign sng_y     = sng_y_q;
    assign sng_rst   = sng_rst_q;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;

endmodule

// File: tb/tb_sc_mac_sequencer.sv
// Directed bench for sc_mac_sequencer with a behavioral counter-SNG/AND
// datapath model; one N_TERMS=4 instance and one N_TERMS=1 instance.
module tb_sc_mac_sequencer;

    localparam int W        = 7;
    localparam int WL       = 1 << W;
    localparam int TERM_CYC = WL + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready, sng_rst, prod_bit;
    logic [W-1:0] in_a, in_b, sng_x, sng_y;
    logic [9:0]   out_acc;

    logic         in_valid_1, in_ready_1, out_valid_1, out_ready_1, sng_rst_1, prod_bit_1;
    logic [W-1:0] in_a_1, in_b_1, sng_x_1, sng_y_1;
    logic [7:0]   out_acc_1;

    int prod_mode;
    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] rev7(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // Behavioral SNG pair: x compares against the counter, y against its bit reversal.
    logic [W-1:0] cnt_m, cnt_m1;
    logic         xb_m, yb_m, xb_m1, yb_m1;

    always_ff @(posedge clk) begin
        if (!sng_rst) begin
            cnt_m <= 7'd0; xb_m <= 1'b0; yb_m <= 1'b0;
        end else begin
            cnt_m <= cnt_m + 7'd1;
            xb_m  <= (sng_x > cnt_m);
            yb_m  <= (sng_y > rev7(cnt_m));
        end
    end

    always_ff @(posedge clk) begin
        if (!sng_rst_1) begin
            cnt_m1 <= 7'd0; xb_m1 <= 1'b0; yb_m1 <= 1'b0;
        end else begin
            cnt_m1 <= cnt_m1 + 7'd1;
            xb_m1  <= (sng_x_1 > cnt_m1);
            yb_m1  <= (sng_y_1 > rev7(cnt_m1));
        end
    end

    assign prod_bit   = (prod_mode == 0) ? 1'b0 : ((prod_mode == 1) ? 1'b1 : (xb_m & yb_m));
    assign prod_bit_1 = xb_m1 & yb_m1;

    sc_mac_sequencer #(.W(W), .N_TERMS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .sng_x(sng_x), .sng_y(sng_y), .sng_rst(sng_rst),
        .prod_bit(prod_bit), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc)
    );

    sc_mac_sequencer #(.W(W), .N_TERMS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .in_a(in_a_1), .in_b(in_b_1), .sng_x(sng_x_1), .sng_y(sng_y_1), .sng_rst(sng_rst_1),
        .prod_bit(prod_bit_1), .out_valid(out_valid_1), .out_ready(out_ready_1), .out_acc(out_acc_1)
    );

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (sng_rst !== 1'b0) begin errors++; $display("FAIL reset_sng_rst: got %b want 0", sng_rst); end
        checks++; if (sng_x !== 7'd0) begin errors++; $display("FAIL reset_sng_x: got %0d want 0", sng_x); end
        checks++; if (out_acc !== 10'd0) begin errors++; $display("FAIL reset_out_acc: got %0d want 0", out_acc); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        checks++; if (sng_rst !== 1'b1) begin errors++; $display("FAIL reset_release_sng_rst: got %b want 1", sng_rst); end
    endtask

    task automatic test_single_term();
        int expc, n, lat, low;
        logic [W-1:0] kv;
        expc = 0;
        for (int k = 0; k < WL; k++) begin
            kv = W'(k);
            if ((7'd64 > kv) && (7'd127 > rev7(kv))) expc++;
        end
        in_a_1 = 7'd64; in_b_1 = 7'd127; out_ready_1 = 1'b0; in_valid_1 = 1'b1;
        n = 0;
        while (in_ready_1 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 in_valid_1 = 1'b0;
        lat = 0; low = 0;
        while (lat < 400) begin
            @(negedge clk); lat++;
            if (sng_rst_1 === 1'b0) low++;
            if (out_valid_1 === 1'b1) break;
        end
        checks++; if (low != 1) begin errors++; $display("FAIL single_sng_rst_low: got %0d cycles want 1", low); end
        checks++; if (lat != TERM_CYC) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, TERM_CYC); end
        checks++; if (out_acc_1 !== 8'(expc)) begin errors++; $display("FAIL single_out_acc: got %0d want %0d", out_acc_1, expc); end
        out_ready_1 = 1'b1;
        @(negedge clk);
        checks++; if (out_valid_1 !== 1'b0) begin errors++; $display("FAIL single_release: got %b want 0", out_valid_1); end
        out_ready_1 = 1'b0;
    endtask

    task automatic test_four_ones();
        int n, lat, acc_n;
        prod_mode = 1; in_a = 7'd127; in_b = 7'd127; out_ready = 1'b0; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        @(posedge clk);
        lat = 0; acc_n = 0;
        while (lat < 700) begin
            @(negedge clk); lat++;
            if (in_ready === 1'b1) acc_n++;
            if (out_valid === 1'b1) break;
        end
        in_valid = 1'b0;
        checks++; if (lat != 4 * TERM_CYC) begin errors++; $display("FAIL ones_latency: got %0d want %0d", lat, 4 * TERM_CYC); end
        checks++; if (out_acc !== 10'd512) begin errors++; $display("FAIL ones_out_acc: got %0d want 512", out_acc); end
        checks++; if (acc_n != 3) begin errors++; $display("FAIL ones_accepts: got %0d want 3", acc_n); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_release: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_zero_hold();
        int n, bad;
        prod_mode = 0; in_a = 7'd100; in_b = 7'd90; out_ready = 1'b0; in_valid = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < 700) begin @(negedge clk); n++; end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_done_timeout: got %b want 1", out_valid); end
        checks++; if (out_acc !== 10'd0) begin errors++; $display("FAIL zero_out_acc: got %0d want 0", out_acc); end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL zero_hold: got %0d bad cycles want 0", bad); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_release_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_release_ready: got %b want 1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_hold_valid();
        int cyc, accepts, bad_x, bad_gap, last;
        logic [W-1:0] exp_x;
        prod_mode = 0; in_a = 7'd10; in_b = 7'd5; out_ready = 1'b0; in_valid = 1'b1;
        cyc = 0; accepts = 0; bad_x = 0; bad_gap = 0; last = 0; exp_x = 7'd0;
        while (cyc < 700) begin
            if (out_valid === 1'b1) break;
            if (in_ready === 1'b1) begin
                if (accepts > 0 && (cyc - last) != TERM_CYC) bad_gap++;
                last = cyc; accepts++; exp_x = in_a;
            end else begin
                if (accepts > 0 && sng_x !== exp_x) bad_x++;
                in_a = in_a + 7'd3;
            end
            @(negedge clk); cyc++;
        end
        in_valid = 1'b0;
        checks++; if (accepts != 4) begin errors++; $display("FAIL hold_accepts: got %0d want 4", accepts); end
        checks++; if (bad_x != 0) begin errors++; $display("FAIL hold_sng_x: got %0d changed cycles want 0", bad_x); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL hold_gap: got %0d bad gaps want 0", bad_gap); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc, n_res, wide;
        logic prev;
        logic [9:0] res0, res1;
        prod_mode = 1; in_a = 7'd127; in_b = 7'd127; out_ready = 1'b1; in_valid = 1'b1;
        cyc = 0; n_res = 0; wide = 0; prev = 1'b0; res0 = 10'd0; res1 = 10'd0;
        while (cyc < 1400 && n_res < 2) begin
            @(negedge clk); cyc++;
            if (out_valid === 1'b1) begin
                if (prev) wide++;
                if (n_res == 0) begin res0 = out_acc; prod_mode = 2; in_a = 7'd64; end
                else res1 = out_acc;
                n_res++;
            end
            prev = out_valid;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done_len: got %b want 0", out_valid); end
        checks++; if (n_res != 2) begin errors++; $display("FAIL b2b_results: got %0d want 2", n_res); end
        checks++; if (res0 !== 10'd512) begin errors++; $display("FAIL b2b_first_acc: got %0d want 512", res0); end
        checks++; if (res1 !== 10'd256) begin errors++; $display("FAIL b2b_second_acc: got %0d want 256", res1); end
        checks++; if (wide != 0) begin errors++; $display("FAIL b2b_wide_done: got %0d want 0", wide); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int n, lat;
        prod_mode = 1; in_a = 7'd127; in_b = 7'd127; out_ready = 1'b0; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        @(posedge clk);
        repeat (TERM_CYC + 2 + 50) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++; if (sng_rst !== 1'b0) begin errors++; $display("FAIL midrst_sng_rst: got %b want 0", sng_rst); end
        checks++; if (out_acc !== 10'd0) begin errors++; $display("FAIL midrst_out_acc: got %0d want 0", out_acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b want 1", in_ready); end
        in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < 700) begin
            @(negedge clk); lat++;
            if (out_valid === 1'b1) break;
        end
        in_valid = 1'b0;
        checks++; if (lat != 4 * TERM_CYC) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", lat, 4 * TERM_CYC); end
        checks++; if (out_acc !== 10'd512) begin errors++; $display("FAIL midrst_out_acc_after: got %0d want 512", out_acc); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        prod_mode = 0;
        in_valid = 1'b0; in_a = 7'd0; in_b = 7'd0; out_ready = 1'b0;
        in_valid_1 = 1'b0; in_a_1 = 7'd0; in_b_1 = 7'd0; out_ready_1 = 1'b0;
        test_reset();
        test_single_term();
        test_four_ones();
        test_zero_hold();
        test_hold_valid();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_mac_sequencer.md
# sc_mac_sequencer

Sequencer for the deterministic stochastic-computing MAC: accepts operand pairs over a valid/ready handshake, drives them into a pair of counter-based stream generators, controls those generators' clear line, and counts the product bitstream over one full 2^W-cycle window per term. After N_TERMS products it presents the accumulated ones-count as a binary result. It sits between the host operand feed and the SNG/AND datapath, and is the only block that resets or sequences the SNGs.

## Interface
- W, 7: operand precision; the stream window is 2^W cycles.
- N_TERMS, 4: products accumulated per result (≥1).
- ACC_W, W+1+clog2(N_TERMS) (10 by default): result width.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  sequencer accepts the pair this cycle
- in_a  in  W  operand A (unsigned fraction, value/2^W)
- in_b  in  W  operand B
- sng_x  out  W  operand A held for SNG x
- sng_y  out  W  operand B held for SNG y
- sng_rst  out  1  active-low clear to both SNGs (counter and output bit)
- prod_bit  in  1  product bit from datapath (x_sn AND y_sn)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_acc  out  ACC_W  accumulated ones-count over N_TERMS windows

## Operation
- States: IDLE, CLEAR, PRIME, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_a→sng_x and in_b→sng_y, then go to CLEAR. If this is the first term of a result, clear acc.
- CLEAR: one cycle with sng_rst=0, so both SNG counters return to 0. Then go to PRIME.
- PRIME: one cycle, sng_rst=1. The SNG registers its first bit (counter=0) at the end of this cycle. prod_bit is ignored. Then go to RUN with win_cnt=0.
- RUN: for 2^W cycles, acc += prod_bit and win_cnt increments. On the cycle with win_cnt=2^W−1, go to IDLE if term_cnt<N_TERMS−1, else go to DONE. term_cnt increments on each window completion.
- DONE: out_valid=1 and out_acc=acc. On out_ready, go to IDLE and reset term_cnt to 0. in_ready=0 in DONE.
- in_ready is 0 in every state except IDLE.
- sng_x and sng_y hold their value from acceptance until the next acceptance.
- Arithmetic: acc is unsigned ACC_W bits. The maximum count is N_TERMS·2^W = 512 at the defaults, so acc never wraps. win_cnt is W+1 bits wide or is compared at 2^W−1.
- sng_rst=0 during reset and during CLEAR only; otherwise it is 1.
- Reset (any state, mid-window included):
  - state=IDLE, acc=0, term_cnt=0, win_cnt=0.
  - sng_x=0, sng_y=0, sng_rst=0 while rst is low.
  - out_valid=0, out_acc=0, in_ready=0 while rst is low, then 1 on the first cycle after release.
  - A partial accumulation is discarded.
- An in_valid held during RUN is not accepted. The operand must remain stable until in_ready.

## Timing
- Acceptance edge t0. CLEAR at t0+1, PRIME at t0+2, RUN from t0+3 to t0+2+2^W.
- A single-term window therefore takes 2^W+2 cycles after acceptance, plus one IDLE cycle before the next acceptance.
- Result latency with N_TERMS=4 and in_valid always high: 4·(2^W+3) cycles from the first acceptance to out_valid.
- out_valid rises on the cycle after the last RUN cycle. It is registered with no combinational path from the inputs.
- out_valid is held until out_ready. With out_ready already high, DONE lasts exactly one cycle.
- The prod_bit sampled in each RUN cycle k (k=0..2^W−1) corresponds to SNG counter value k.

## Structure
- Shared SC package holds:
  - state enum (IDLE, CLEAR, PRIME, RUN, DONE)
  - default W
  - ACC_W function
  - window length constant 2^W
- One natural sub-module, sc_window_counter:
  - W+1-bit counter with clear, enable and a last-cycle flag.
  - It is reused by other SC blocks that need window framing.
- The FSM, operand registers and accumulator stay in sc_mac_sequencer.

## Test plan
- Reset mid-RUN (after 50 cycles of window 2):
  - Required: out_valid=0, acc=0 and sng_rst=0 during reset.
  - Required: in_ready=1 one cycle after release.
  - Required: a fresh 4-term sequence then gives the correct result.
- Single term, N_TERMS=1, a=64, b=127, with a behavioral SNG/AND model:
  - Required: sng_rst low exactly 1 cycle.
  - Required: out_valid at acceptance+2^W+3.
  - Required: out_acc equals the model's ones-count.
- Four terms, a=b=127 each, prod_bit forced to 1:
  - Required: out_acc=512.
  - Required: the count does not wrap at ACC_W=10.
- prod_bit forced to 0 for all terms:
  - Required: out_acc=0.
  - Required: out_valid held for 20 cycles with out_ready=0, with in_ready=0 throughout.
  - Required: release occurs on out_ready.
- in_valid held high during RUN with changing in_a:
  - Required: sng_x stays unchanged until the next IDLE.
  - Required: exactly one acceptance per window.
- Back-to-back results with out_ready tied to 1:
  - Required: DONE lasts 1 cycle.
  - Required: the second result starts from acc=0.
